// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides Clk down to the pixel rate and produces
// coordinates, syncs, blank, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    // 11-bit bounds so a 1024-wide total still compares correctly
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_pclk;
    logic             r_pix_en;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank;
    logic             r_line_start;
    logic             r_frame_start;
    logic [7:0]       r_frame_count;

    logic             w_div_last;
    logic [DIV_W-1:0] w_div_nxt;
    logic [9:0]       w_x_nxt;
    logic [9:0]       w_y_nxt;
    logic             w_line_wrap;
    logic             w_frame_wrap;
    logic [10:0]      w_x_ext;
    logic [10:0]      w_y_ext;
    logic             w_hs_nxt;
    logic             w_vs_nxt;
    logic             w_blank_nxt;

    // Next-state of the divider and raster counters
    always_comb begin
        w_div_last   = (r_div_cnt == DIV_LAST);
        w_div_nxt    = w_div_last ? {DIV_W{1'b0}} : (r_div_cnt + DIV_W'(1));
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_line_wrap  = 1'b0;
        w_frame_wrap = 1'b0;
        if (w_div_last) begin
            if ({1'b0, r_x} == H_LAST) begin
                w_x_nxt     = 10'd0;
                w_line_wrap = 1'b1;
                if ({1'b0, r_y} == V_LAST) begin
                    w_y_nxt      = 10'd0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_y_nxt = r_y + 10'd1;
                end
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end else begin
            w_x_nxt = r_x;
        end
    end

    // Sync/blank decoded from the next coordinates so they land with them
    always_comb begin
        w_x_ext     = {1'b0, w_x_nxt};
        w_y_ext     = {1'b0, w_y_nxt};
        w_hs_nxt    = !((w_x_ext >= HS_START) && (w_x_ext < HS_END));
        w_vs_nxt    = !((w_y_ext >= VS_START) && (w_y_ext < VS_END));
        w_blank_nxt = (w_x_ext < H_VIS) && (w_y_ext < V_VIS);
    end

    // All timing state; outputs only move on a pixel advance except strobes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div_cnt     <= {DIV_W{1'b0}};
            r_pclk        <= 1'b0;
            r_pix_en      <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_div_cnt     <= w_div_nxt;
            r_pclk        <= (w_div_nxt >= DIV_HALF);
            r_pix_en      <= w_div_last;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
            if (w_div_last) begin
                r_x     <= w_x_nxt;
                r_y     <= w_y_nxt;
                r_hs    <= w_hs_nxt;
                r_vs    <= w_vs_nxt;
                r_blank <= w_blank_nxt;
            end
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign pixel_clk   = r_pclk;
    assign pix_en      = r_pix_en;
    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign sync        = 1'b0;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, reduced-size instance
// (12x8 raster) for frame, mid-frame reset and frame-counter wrap checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b;
    logic rst_s;

    logic       b_pclk, b_pe, b_hs, b_vs, b_blank, b_sync, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic [7:0] b_fc;
    logic       s_pclk, s_pe, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    vga_timing_gen u_big (
        .Clk(clk), .Reset(rst_b), .pixel_clk(b_pclk), .pix_en(b_pe),
        .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs), .blank(b_blank),
        .sync(b_sync), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .Clk(clk), .Reset(rst_s), .pixel_clk(s_pclk), .pix_en(s_pe),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .sync(s_sync), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    int errors = 0;
    int checks = 0;

    int cyc, ls_cnt, ls_first, x_after_ls, y_after_ls, hs_low, hs_first_x;
    int blank_low, pe_cnt, coh_bad, pclk_bad, xchg_bad, max_x;
    int fs_cnt, fs_first, fs_x, fs_y, fs_no_ls, vs_low, fs_wide, fc_at_256, found;
    logic [9:0] prev_x;
    logic       prev_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b1;
        rst_s = 1'b1;
        repeat (5) tick();

        check("rst_x", b_x, 0);
        check("rst_y", b_y, 0);
        check("rst_pclk", b_pclk, 0);
        check("rst_pix_en", b_pe, 0);
        check("rst_hs", b_hs, 1);
        check("rst_vs", b_vs, 1);
        check("rst_blank", b_blank, 0);
        check("rst_sync", b_sync, 0);
        check("rst_line_start", b_ls, 0);
        check("rst_frame_start", b_fs, 0);
        check("rst_frame_count", b_fc, 0);

        rst_b = 1'b0;
        rst_s = 1'b0;
        tick();
        check("c1_pclk", b_pclk, 1);
        check("c1_pix_en", b_pe, 0);
        check("c1_x", b_x, 0);
        check("c1_blank", b_blank, 0);
        tick();
        check("c2_pix_en", b_pe, 1);
        check("c2_x", b_x, 1);
        check("c2_pclk", b_pclk, 0);
        check("c2_blank", b_blank, 1);
        check("c2_hs", b_hs, 1);
        tick();
        check("c3_pix_en", b_pe, 0);
        check("c3_x", b_x, 1);
        check("c3_pclk", b_pclk, 1);

        // One full 800-pixel line on the default-size instance
        cyc = 3; ls_cnt = 0; ls_first = -1; x_after_ls = -1; y_after_ls = -1;
        hs_low = 0; hs_first_x = -1; blank_low = 0; pe_cnt = 0; coh_bad = 0;
        pclk_bad = 0; xchg_bad = 0; max_x = 0; prev_x = b_x;
        for (int i = 0; i < 1700; i++) begin
            tick();
            cyc++;
            if (b_ls) begin
                ls_cnt++;
                if (ls_first < 0) begin
                    ls_first = cyc; x_after_ls = int'(b_x); y_after_ls = int'(b_y);
                end
            end
            if (!b_hs) begin
                hs_low++;
                if (hs_first_x < 0) hs_first_x = int'(b_x);
            end
            if (!b_blank) blank_low++;
            if (b_pe) begin
                pe_cnt++;
                if ((b_blank !== ((b_x < 10'd640) && (b_y < 10'd480))) ||
                    (b_hs !== !((b_x >= 10'd656) && (b_x < 10'd752))) ||
                    (b_vs !== !((b_y >= 10'd490) && (b_y < 10'd492))))
                    coh_bad++;
            end
            if (b_pclk !== ((cyc % 2) == 1)) pclk_bad++;
            if ((b_x != prev_x) && !b_pe) xchg_bad++;
            if (int'(b_x) > max_x) max_x = int'(b_x);
            prev_x = b_x;
        end
        check("line_ls_count", ls_cnt, 1);
        check("line_ls_cycle", ls_first, 1600);
        check("line_x_after_wrap", x_after_ls, 0);
        check("line_y_after_wrap", y_after_ls, 1);
        check("line_hs_low_clks", hs_low, 192);
        check("line_hs_first_x", hs_first_x, 656);
        check("line_blank_low_clks", blank_low, 320);
        check("line_pix_en_count", pe_cnt, 850);
        check("line_coherence_bad", coh_bad, 0);
        check("line_pclk_bad", pclk_bad, 0);
        check("line_x_change_off_pix_en", xchg_bad, 0);
        check("line_max_x", max_x, 799);

        // Small raster: 12x8 pixels, 192 Clk per frame
        rst_s = 1'b1;
        tick();
        tick();
        check("srst_x", s_x, 0);
        check("srst_y", s_y, 0);
        check("srst_hs", s_hs, 1);
        check("srst_vs", s_vs, 1);
        check("srst_fc", s_fc, 0);
        rst_s = 1'b0;

        cyc = 0; fs_cnt = 0; fs_first = -1; fs_x = -1; fs_y = -1; fs_no_ls = 0;
        ls_cnt = 0; vs_low = 0; hs_low = 0; coh_bad = 0;
        for (int i = 0; i < 202; i++) begin
            tick();
            cyc++;
            if (s_fs) begin
                fs_cnt++;
                if (fs_first < 0) begin
                    fs_first = cyc; fs_x = int'(s_x); fs_y = int'(s_y);
                end
                if (!s_ls) fs_no_ls++;
            end
            if (s_ls) ls_cnt++;
            if (!s_vs) vs_low++;
            if (!s_hs) hs_low++;
            if (s_pe) begin
                if ((s_blank !== ((s_x < 10'd6) && (s_y < 10'd4))) ||
                    (s_hs !== !((s_x >= 10'd8) && (s_x < 10'd11))) ||
                    (s_vs !== !((s_y >= 10'd5) && (s_y < 10'd7))))
                    coh_bad++;
            end
        end
        check("frame_fs_cycle", fs_first, 192);
        check("frame_fs_count", fs_cnt, 1);
        check("frame_fs_x", fs_x, 0);
        check("frame_fs_y", fs_y, 0);
        check("frame_fs_without_ls", fs_no_ls, 0);
        check("frame_ls_count", ls_cnt, 8);
        check("frame_vs_low_clks", vs_low, 48);
        check("frame_hs_low_clks", hs_low, 48);
        check("frame_coherence_bad", coh_bad, 0);
        check("frame_count_after", s_fc, 1);

        // Reset inside both sync pulses
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if ((s_x == 10'd9) && (s_y == 10'd6)) found = 1;
        end
        check("mid_found", found, 1);
        check("mid_hs_before", s_hs, 0);
        check("mid_vs_before", s_vs, 0);
        check("mid_fc_before", s_fc, 1);
        rst_s = 1'b1;
        tick();
        check("mid_x", s_x, 0);
        check("mid_y", s_y, 0);
        check("mid_hs", s_hs, 1);
        check("mid_vs", s_vs, 1);
        check("mid_blank", s_blank, 0);
        check("mid_fc", s_fc, 0);
        check("mid_ls", s_ls, 0);
        check("mid_fs", s_fs, 0);
        check("mid_pix_en", s_pe, 0);
        check("mid_pclk", s_pclk, 0);
        rst_s = 1'b0;
        tick();
        tick();
        check("mid_rel_x", s_x, 1);
        check("mid_rel_blank", s_blank, 1);

        // 257 frames: counter wraps 255 -> 0 -> 1
        fs_cnt = 0; fs_wide = 0; fc_at_256 = -1; prev_fs = 1'b0;
        for (int i = 0; i < 257 * 192 + 20; i++) begin
            tick();
            if (s_fs) begin
                fs_cnt++;
                if (prev_fs) fs_wide++;
                if (fs_cnt == 256) fc_at_256 = int'(s_fc);
            end
            prev_fs = s_fs;
        end
        check("wrap_fs_count", fs_cnt, 257);
        check("wrap_fs_wide", fs_wide, 0);
        check("wrap_fc_at_256", fc_at_256, 0);
        check("wrap_fc_final", s_fc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
